// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   start      operation request, sampled only in IDLE
//   dividend   DVD_W-bit dividend, captured on the accepting edge
//   divisor    DVS_W-bit divisor, captured on the accepting edge
//   busy       high whenever the FSM is not in IDLE
//   done       single-cycle pulse; quotient/remainder/div_zero valid
//   quotient   registered DVD_W-bit result, held until the next completion
//   remainder  registered DVS_W-bit result, held until the next completion
//   div_zero   registered; set when the completed operation had divisor == 0
//
// Latency: normal path holds busy for 18 cycles, with done high in the
// last one. A zero divisor completes with done high in the second cycle
// after accept.
module seq_divider #(
  parameter int unsigned DVD_W = 16,
  parameter int unsigned DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(DVD_W) + 1;
  localparam logic [CW-1:0] ITERS = CW'(DVD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DVD_W-1:0] dq;       // dividend shifting out, quotient shifting in
  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] pr;       // partial remainder; its top bit is always 0 between iterations, so it is not stored
  logic [CW-1:0]    count;

  logic [DVS_W:0]   shifted;
  logic [DVS_W:0]   diff;
  logic             qbit;
  logic             zero_dvs;
  logic             calc_end;

  // shifted < 2*dvs, so a 9-bit difference is non-negative in 0..dvs-1 and
  // wraps to the upper half on a borrow: diff[MSB] is the borrow flag.
  assign shifted  = {pr, dq[DVD_W-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign qbit     = ~diff[DVS_W];
  assign zero_dvs = (dvs == '0);
  // Iterations run on count 0..DVD_W-1; the count==DVD_W cycle is the
  // hand-off into DONE, matching the published latency.
  assign calc_end = (count == ITERS);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: if (zero_dvs || calc_end) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq        <= '0;
      dvs       <= '0;
      pr        <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dq    <= dividend;
            dvs   <= divisor;
            pr    <= '0;
            count <= '0;
          end
        end
        CALC: begin
          if (!zero_dvs && !calc_end) begin
            pr    <= qbit ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];
            dq    <= {dq[DVD_W-2:0], qbit};
            count <= count + CW'(1);
          end
          if (zero_dvs) begin
            // dq still holds the untouched dividend on this path
            quotient  <= '1;
            remainder <= dq[DVS_W-1:0];
            div_zero  <= 1'b1;
          end else if (calc_end) begin
            quotient  <= dq;
            remainder <= pr;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  seq_divider #(.DVD_W(16), .DVS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } res_t;

  res_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse pops and compares one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("quotient", {16'd0, quotient}, {16'd0, e.q});
        check("remainder", {24'd0, remainder}, {24'd0, e.r});
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
    res_t m;
    if (b == 8'd0) begin
      m.q = 16'hFFFF; m.r = a[7:0]; m.dz = 1'b1;
    end else begin
      m.q = a / {8'd0, b}; m.r = 8'(a % {8'd0, b}); m.dz = 1'b0;
    end
    return m;
  endfunction

  // Drive one request at the negedge; returns #1 after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input bit push);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follow one operation: first done offset, done cycles and busy cycles,
  // counted from the accepting edge. Optionally disturb the inputs mid-flight.
  task automatic wait_op(input string tag, input int exp_first, input int exp_busy, input int disturb_at);
    int k = 0, nb = 0, nd = 0, first = -1;
    while (k < 40) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (first < 0) first = k;
      end
      if (!busy) break;
      if (k == disturb_at) begin
        start = 1'b1; dividend = 16'd50; divisor = 8'd5;
      end else if (k == disturb_at + 1) begin
        start = 1'b0; dividend = 16'hBEEF; divisor = 8'h3C;
      end
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_done_at"}, 32'(first), 32'(exp_first));
    check({tag, "_done_cnt"}, 32'(nd), 32'd1);
    check({tag, "_busy_cyc"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    int k;
    int t[3];
    int n;
    logic prev;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {16'd0, quotient}, 32'd0);
    check("rst_r", {24'd0, remainder}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operations
    start_op(16'd100, 8'd7, 1'b1);   wait_op("op100_7", 17, 18, -10);
    start_op(16'd65535, 8'd1, 1'b1); wait_op("op65535_1", 17, 18, -10);
    start_op(16'd65535, 8'd255, 1'b1); wait_op("op65535_255", 17, 18, -10);
    start_op(16'd5, 8'd9, 1'b1);     wait_op("op5_9", 17, 18, -10);

    // Divide by zero, then a normal op clears div_zero
    start_op(16'd1234, 8'd0, 1'b1);  wait_op("op1234_0", 1, 2, -10);
    start_op(16'd10, 8'd3, 1'b1);    wait_op("op10_3", 17, 18, -10);
    repeat (3) @(negedge clk);
    check("hold_q", {16'd0, quotient}, 32'd3);
    check("hold_r", {24'd0, remainder}, 32'd1);

    // start while busy is ignored, operand changes after accept have no effect
    start_op(16'd100, 8'd7, 1'b1);   wait_op("busy_start", 17, 18, 5);

    // Asynchronous reset mid-CALC: abandoned, nothing pushed
    start_op(16'd100, 8'd7, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_q", {16'd0, quotient}, 32'd0);
    check("arst_r", {24'd0, remainder}, 32'd0);
    check("arst_dz", {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);      // any stray done is flagged by the scoreboard
    start_op(16'd9, 8'd2, 1'b1);     wait_op("op9_2", 17, 18, -10);

    // start held high: back-to-back accepts, done 19 cycles apart
    @(negedge clk);
    dividend = 16'd40000;
    divisor  = 8'd200;
    start    = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(16'd40000, 8'd200));
    @(posedge clk);
    #1;
    k = 0; n = 0; prev = 1'b0;
    while (k < 120) begin
      if (done && !prev) begin
        if (n < 3) t[n] = k;
        n++;
        if (n == 3) start = 1'b0;
      end
      prev = done;
      if (n >= 3 && !busy) break;
      @(posedge clk);
      #1;
      k++;
    end
    check("b2b_count", 32'(n), 32'd3);
    check("b2b_first", 32'(t[0]), 32'd17);
    check("b2b_gap1", 32'(t[1] - t[0]), 32'd19);
    check("b2b_gap2", 32'(t[2] - t[1]), 32'd19);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
